// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, sequencer state encoding and processing_unit opcodes.
package alu_pkg;
    localparam int SEL_W = 3;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam logic [SEL_W-1:0] OP_SEL0 = 3'b000;
    localparam logic [SEL_W-1:0] OP_SEL1 = 3'b001;
    localparam logic [SEL_W-1:0] OP_SEL2 = 3'b010;
    localparam logic [SEL_W-1:0] OP_SEL3 = 3'b011;
    localparam logic [SEL_W-1:0] OP_SEL4 = 3'b100;
    localparam logic [SEL_W-1:0] OP_SEL5 = 3'b101;
    localparam logic [SEL_W-1:0] OP_SEL6 = 3'b110;
    localparam logic [SEL_W-1:0] OP_SEL7 = 3'b111;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front-end that registers ALU inputs, waits one settle cycle,
// captures the result and chains it through an accumulator.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic [SEL_W-1:0] cmd_op,
    input  logic             cmd_use_acc,
    output logic [N-1:0]     alu_dataa,
    output logic [N-1:0]     alu_datab,
    output logic [SEL_W-1:0] alu_selop,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             res_cout,
    output logic             res_zero,
    output logic [CW-1:0]    op_count
);
    state_t             r_state, w_next;
    logic [N-1:0]       r_dataa, r_datab, r_acc, r_res_data;
    logic [SEL_W-1:0]   r_selop;
    logic               r_res_cout, r_res_zero;
    logic [CW-1:0]      r_op_count;
    logic               w_accept, w_capture, w_retire;

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    assign w_capture = (r_state == EXEC);
    assign w_retire  = (r_state == DONE) && res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = w_accept ? EXEC : w_capture ? DONE : w_retire ? IDLE : r_state;
    end

    // ALU drive only moves on acceptance, so the ALU never sees mid-operation changes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dataa    <= '0;
            r_datab    <= '0;
            r_selop    <= '0;
            r_acc      <= '0;
            r_res_data <= '0;
            r_res_cout <= 1'b0;
            r_res_zero <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_dataa <= cmd_use_acc ? r_acc : cmd_a;
                r_datab <= cmd_b;
                r_selop <= cmd_op;
            end
            if (w_capture) begin
                r_res_data <= alu_result;
                r_res_cout <= alu_cout;
                r_res_zero <= (alu_result == '0);
                r_acc      <= alu_result;
            end
            if (w_retire) r_op_count <= r_op_count + CW'(1);
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign res_valid = (r_state == DONE);
    assign alu_dataa = r_dataa;
    assign alu_datab = r_datab;
    assign alu_selop = r_selop;
    assign res_data  = r_res_data;
    assign res_cout  = r_res_cout;
    assign res_zero  = r_res_zero;
    assign op_count  = r_op_count;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors against the sequencer with an adder stub as the ALU.
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_use_acc = 1'b0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [7:0] alu_dataa, alu_datab, alu_result;
    logic [2:0] alu_selop;
    logic       alu_cout;
    logic       res_valid, res_ready = 1'b0, res_cout, res_zero;
    logic [7:0] res_data, op_count;
    int         n_cmp = 0, n_err = 0;
    int         exp_cnt = 0;

    always #5 clk = ~clk;

    assign {alu_cout, alu_result} = {1'b0, alu_dataa} + {1'b0, alu_datab};

    alu_op_sequencer #(.N(8), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
        .alu_dataa(alu_dataa), .alu_datab(alu_datab), .alu_selop(alu_selop),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout), .res_zero(res_zero),
        .op_count(op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // starts in IDLE at a negedge; expected values are hand-computed by the caller
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic ua, input logic [7:0] ea,
                          input logic [7:0] eres, input logic ecout, input logic ezero);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua; cmd_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, ".dataa"}, alu_dataa, ea);
        check({tag, ".datab"}, alu_datab, b);
        check({tag, ".selop"}, alu_selop, op);
        check({tag, ".exec_valid"}, res_valid, 0);
        check({tag, ".exec_ready"}, cmd_ready, 0);
        @(negedge clk);
        check({tag, ".valid"}, res_valid, 1);
        check({tag, ".data"}, res_data, eres);
        check({tag, ".cout"}, res_cout, ecout);
        check({tag, ".zero"}, res_zero, ezero);
        @(negedge clk);
        exp_cnt = (exp_cnt + 1) % 256;
        check({tag, ".count"}, op_count, exp_cnt);
        check({tag, ".idle"}, cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst.valid", res_valid, 0);
        check("rst.data", res_data, 0);
        check("rst.cout", res_cout, 0);
        check("rst.zero", res_zero, 0);
        check("rst.count", op_count, 0);
        check("rst.dataa", alu_dataa, 0);
        check("rst.datab", alu_datab, 0);
        check("rst.selop", alu_selop, 0);
        rst_n = 1'b1;
        check("rst.ready", cmd_ready, 1);

        run_op("single", 8'h02, 8'h01, 3'b001, 1'b0, 8'h02, 8'h03, 1'b0, 1'b0);
        run_op("carry",  8'hFF, 8'h01, 3'b001, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
        run_op("chain0", 8'h05, 8'h03, 3'b010, 1'b0, 8'h05, 8'h08, 1'b0, 1'b0);
        run_op("chain1", 8'hAA, 8'h02, 3'b011, 1'b1, 8'h08, 8'h0A, 1'b0, 1'b0);

        // backpressure with a competing command held on the input
        res_ready = 1'b0;
        cmd_a = 8'h10; cmd_b = 8'h20; cmd_op = 3'b101; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_a = 8'h40; cmd_b = 8'h01; cmd_op = 3'b110;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp.valid", res_valid, 1);
            check("bp.ready", cmd_ready, 0);
            check("bp.data", res_data, 8'h30);
            check("bp.dataa", alu_dataa, 8'h10);
            check("bp.datab", alu_datab, 8'h20);
            check("bp.selop", alu_selop, 3'b101);
            check("bp.count", op_count, exp_cnt);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check("bp.release_count", op_count, exp_cnt);
        check("bp.release_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp.next_dataa", alu_dataa, 8'h40);
        check("bp.next_selop", alu_selop, 3'b110);
        @(negedge clk);
        check("bp.next_data", res_data, 8'h41);
        @(negedge clk);
        exp_cnt++;
        check("bp.next_count", op_count, exp_cnt);

        // reset during EXEC drops the operation and clears the accumulator
        cmd_a = 8'h07; cmd_b = 8'h01; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.valid", res_valid, 0);
        check("midrst.count", op_count, 0);
        check("midrst.data", res_data, 0);
        @(negedge clk);
        check("midrst.still_no_valid", res_valid, 0);
        exp_cnt = 0;
        run_op("midrst.acc", 8'h55, 8'h00, 3'b000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

        // 255 more operations bring the counter back to zero
        res_ready = 1'b1; cmd_use_acc = 1'b0; cmd_a = 8'h01; cmd_b = 8'h01;
        for (int i = 0; i < 255; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            if (i == 253) check("wrap.max", op_count, 8'hFF);
        end
        check("wrap.zero", op_count, 0);
        check("wrap.idle", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
